interrupt_ctrl: RTL and testbench

- Prioritised interrupt controller between the four peripheral interrupt lines (timer and external sources) and the single-cycle CPU.
- Latches rising edges into pending bits and masks them with a CPU-written enable register.
- Presents one request at a time to the CPU, with a jump vector.
- Runs the request/acknowledge/end-of-interrupt handshake and forbids nesting.

---
 rtl/interrupt_ctrl_pkg.sv | 27 ++
 rtl/interrupt_ctrl_if.sv | 33 +++
 rtl/interrupt_ctrl_irq_edge_latch.sv | 50 +++++
 rtl/interrupt_ctrl.sv | 122 ++++++++++++
 tb/tb_interrupt_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl_pkg
// Shared constants for the interrupt controller:
//   - FSM state encodings (IDLE / REQ / SERVICE)
//   - configuration register bit positions
//   - number of interrupt lines
//   - vector address helper
// No ports (package).
// -----------------------------------------------------------------------------
package interrupt_ctrl_pkg;

  localparam int N_IRQ      = 4;
  localparam int CFG_GEN    = 7;
  localparam int CFG_EN_MSB = 3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  // ISR address for a line; 10-bit arithmetic, wraps modulo 1024.
  function automatic logic [9:0] vec_addr(input logic [9:0] base,
                                          input logic [9:0] stride,
                                          input logic [1:0] id);
    return base + stride * {8'd0, id};
  endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl_if
// Bundles the peripheral interrupt lines, the CPU configuration write port and
// the CPU request/ack/eoi handshake with the status outputs.
//   master : CPU / peripheral side (drives irq, cfg_*, int_ack, int_eoi)
//   slave  : interrupt controller side (drives int_req, int_vec, pending,
//            in_service, active_id)
// -----------------------------------------------------------------------------
interface interrupt_ctrl_if;
  import interrupt_ctrl_pkg::*;

  logic [N_IRQ-1:0] irq;
  logic             cfg_we;
  logic [7:0]       cfg_data;
  logic             int_req;
  logic [9:0]       int_vec;
  logic             int_ack;
  logic             int_eoi;
  logic [N_IRQ-1:0] pending;
  logic             in_service;
  logic [1:0]       active_id;

  modport master (
    output irq, cfg_we, cfg_data, int_ack, int_eoi,
    input  int_req, int_vec, pending, in_service, active_id
  );

  modport slave (
    input  irq, cfg_we, cfg_data, int_ack, int_eoi,
    output int_req, int_vec, pending, in_service, active_id
  );

endinterface

// File: rtl/interrupt_ctrl_irq_edge_latch.sv
// -----------------------------------------------------------------------------
// irq_edge_latch
// One rising-edge detector per interrupt line feeding a pending bit.
// A rise sets the bit; an acknowledge clears the bit of the acknowledged line,
// but a rise in the same cycle wins so that event is not lost.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_irq       : raw interrupt lines
//   i_clr       : clear strobe (acknowledge accepted)
//   i_clr_id    : line to clear
//   o_pending   : latched, not-yet-acknowledged events
// -----------------------------------------------------------------------------
module irq_edge_latch
  import interrupt_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_clr,
  input  logic [1:0]       i_clr_id,
  output logic [N_IRQ-1:0] o_pending
);

  logic [N_IRQ-1:0] r_irq_q;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] w_rise;

  always_ff @(posedge clk) begin
    if (reset) r_irq_q <= '0;
    else       r_irq_q <= i_irq;
  end

  assign w_rise = i_irq & ~r_irq_q;

  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
      always_ff @(posedge clk) begin
        if (reset)
          r_pending[gi] <= 1'b0;
        else if (w_rise[gi])
          r_pending[gi] <= 1'b1;    // set beats clear
        else if (i_clr && (i_clr_id == 2'(gi)))
          r_pending[gi] <= 1'b0;
      end
    end
  endgenerate

  assign o_pending = r_pending;

endmodule

// File: rtl/interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl
// Prioritised, non-nesting interrupt controller for four lines.
// Rising edges latch into pending bits; pending & enable & gen are arbitrated
// (lowest index wins) and presented one at a time to the CPU with a vector.
// Handshake: IDLE -> REQ (int_req) -> ack -> SERVICE (in_service) -> eoi -> IDLE.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : interrupt_ctrl_if.slave (irq, cfg_we/cfg_data, int_req,
//                int_vec, int_ack, int_eoi, pending, in_service, active_id)
// Parameters:
//   VEC_BASE   : vector address of line 0
//   VEC_STRIDE : address distance between line vectors
// -----------------------------------------------------------------------------
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter logic [9:0] VEC_BASE   = 10'h3C0,
  parameter logic [9:0] VEC_STRIDE = 10'd16
) (
  input  logic              clk,
  input  logic              reset,
  interrupt_ctrl_if.slave   bus
);

  logic [1:0]       r_state;
  logic [N_IRQ-1:0] r_enable;
  logic             r_gen;
  logic             r_int_req;
  logic [9:0]       r_int_vec;
  logic             r_in_service;
  logic [1:0]       r_active_id;

  logic [N_IRQ-1:0] w_pending;
  logic [N_IRQ-1:0] w_eligible;
  logic [1:0]       w_winner;
  logic             w_ack_take;
  logic             w_cfg_unused;

  // Reserved configuration bits carry no function.
  assign w_cfg_unused = ^bus.cfg_data[6:4];

  // An ack is only honoured while a request is outstanding.
  assign w_ack_take = (r_state == REQ) && bus.int_ack;

  irq_edge_latch u_edge_latch (
    .clk       (clk),
    .reset     (reset),
    .i_irq     (bus.irq),
    .i_clr     (w_ack_take),
    .i_clr_id  (r_active_id),
    .o_pending (w_pending)
  );

  // Uses the enable/gen registers as they were before any same-cycle write.
  assign w_eligible = w_pending & r_enable & {N_IRQ{r_gen}};

  // Priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    w_winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable <= '0;
      r_gen    <= 1'b0;
    end else if (bus.cfg_we) begin
      r_enable <= bus.cfg_data[CFG_EN_MSB:0];
      r_gen    <= bus.cfg_data[CFG_GEN];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_int_req    <= 1'b0;
      r_int_vec    <= VEC_BASE;
      r_in_service <= 1'b0;
      r_active_id  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_eligible != '0) begin
            r_state     <= REQ;
            r_active_id <= w_winner;
            r_int_vec   <= vec_addr(VEC_BASE, VEC_STRIDE, w_winner);
            r_int_req   <= 1'b1;
          end
        end
        REQ: begin
          // Request is frozen until acked; eoi in this state is ignored.
          if (bus.int_ack) begin
            r_int_req    <= 1'b0;
            r_in_service <= 1'b1;
            r_state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.int_eoi) begin
            r_in_service <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_int_req    <= 1'b0;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_req    = r_int_req;
  assign bus.int_vec    = r_int_vec;
  assign bus.pending    = w_pending;
  assign bus.in_service = r_in_service;
  assign bus.active_id  = r_active_id;

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  interrupt_ctrl_if bus_if ();

  interrupt_ctrl #(
    .VEC_BASE   (10'h3C0),
    .VEC_STRIDE (10'd16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [9:0] vec,
                         input logic [1:0] id, input logic svc, input logic [3:0] pend);
    chk({tag, ".int_req"},    32'(bus_if.int_req),    32'(req));
    chk({tag, ".int_vec"},    32'(bus_if.int_vec),    32'(vec));
    chk({tag, ".active_id"},  32'(bus_if.active_id),  32'(id));
    chk({tag, ".in_service"}, 32'(bus_if.in_service), 32'(svc));
    chk({tag, ".pending"},    32'(bus_if.pending),    32'(pend));
  endtask

  task automatic cfg(input logic [7:0] d);
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_data = d;
    tick();
    bus_if.cfg_we   = 1'b0;
  endtask

  task automatic pulse_ack();
    bus_if.int_ack = 1'b1;
    tick();
    bus_if.int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus_if.int_eoi = 1'b1;
    tick();
    bus_if.int_eoi = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus_if.irq      = 4'b0000;
    bus_if.cfg_we   = 1'b0;
    bus_if.cfg_data = 8'h00;
    bus_if.int_ack  = 1'b0;
    bus_if.int_eoi  = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk_all("reset", 1'b0, 10'h3C0, 2'd0, 1'b0, 4'b0000);
    reset = 1'b0;

    // Basic flow on line 0
    cfg(8'h81);
    bus_if.irq = 4'b0001;
    tick();
    chk_all("t1_pend", 1'b0, 10'h3C0, 2'd0, 1'b0, 4'b0001);
    bus_if.irq = 4'b0000;
    tick();
    chk_all("t1_req", 1'b1, 10'h3C0, 2'd0, 1'b0, 4'b0001);
    pulse_ack();
    chk_all("t1_ack", 1'b0, 10'h3C0, 2'd0, 1'b1, 4'b0000);
    pulse_eoi();
    chk_all("t1_eoi", 1'b0, 10'h3C0, 2'd0, 1'b0, 4'b0000);
    tick();
    chk_all("t1_idle", 1'b0, 10'h3C0, 2'd0, 1'b0, 4'b0000);

    // Simultaneous priority, levels held high
    cfg(8'h8F);
    bus_if.irq = 4'b1010;
    tick();
    chk_all("t2_pend", 1'b0, 10'h3C0, 2'd0, 1'b0, 4'b1010);
    tick();
    chk_all("t2_req1", 1'b1, 10'h3D0, 2'd1, 1'b0, 4'b1010);
    pulse_ack();
    chk_all("t2_ack1", 1'b0, 10'h3D0, 2'd1, 1'b1, 4'b1000);
    pulse_eoi();
    chk_all("t2_eoi1", 1'b0, 10'h3D0, 2'd1, 1'b0, 4'b1000);
    tick();
    chk_all("t2_req3", 1'b1, 10'h3F0, 2'd3, 1'b0, 4'b1000);
    pulse_ack();
    chk_all("t2_ack3", 1'b0, 10'h3F0, 2'd3, 1'b1, 4'b0000);
    pulse_eoi();
    bus_if.irq = 4'b0000;
    tick();
    chk_all("t2_level", 1'b0, 10'h3F0, 2'd3, 1'b0, 4'b0000);

    // Masking, and cfg write racing arbitration
    cfg(8'h84);
    bus_if.irq = 4'b0010;
    tick();
    bus_if.irq = 4'b0000;
    tick();
    chk_all("t3_masked", 1'b0, 10'h3F0, 2'd3, 1'b0, 4'b0010);
    cfg(8'h86);
    chk_all("t3_oldcfg", 1'b0, 10'h3F0, 2'd3, 1'b0, 4'b0010);
    tick();
    chk_all("t3_unmask", 1'b1, 10'h3D0, 2'd1, 1'b0, 4'b0010);
    pulse_ack();
    pulse_eoi();
    cfg(8'h0F);
    bus_if.irq = 4'b0001;
    tick();
    bus_if.irq = 4'b0000;
    tick();
    tick();
    chk_all("t3_gen0", 1'b0, 10'h3D0, 2'd1, 1'b0, 4'b0001);
    cfg(8'h81);
    tick();
    chk_all("t3_gen1", 1'b1, 10'h3C0, 2'd0, 1'b0, 4'b0001);
    pulse_ack();
    pulse_eoi();

    // No pre-emption
    cfg(8'h8F);
    bus_if.irq = 4'b0100;
    tick();
    bus_if.irq = 4'b0000;
    tick();
    chk_all("t4_req2", 1'b1, 10'h3E0, 2'd2, 1'b0, 4'b0100);
    bus_if.irq = 4'b0001;
    tick();
    bus_if.irq = 4'b0000;
    chk_all("t4_frozen", 1'b1, 10'h3E0, 2'd2, 1'b0, 4'b0101);
    pulse_ack();
    chk_all("t4_ack", 1'b0, 10'h3E0, 2'd2, 1'b1, 4'b0001);
    tick();
    chk_all("t4_nonest", 1'b0, 10'h3E0, 2'd2, 1'b1, 4'b0001);
    pulse_eoi();
    chk_all("t4_eoi", 1'b0, 10'h3E0, 2'd2, 1'b0, 4'b0001);
    tick();
    chk_all("t4_req0", 1'b1, 10'h3C0, 2'd0, 1'b0, 4'b0001);
    pulse_ack();
    pulse_eoi();

    // Set beats clear
    bus_if.irq = 4'b0100;
    tick();
    bus_if.irq = 4'b0000;
    tick();
    chk_all("t5_req2", 1'b1, 10'h3E0, 2'd2, 1'b0, 4'b0100);
    bus_if.irq     = 4'b0100;
    bus_if.int_ack = 1'b1;
    tick();
    bus_if.irq     = 4'b0000;
    bus_if.int_ack = 1'b0;
    chk_all("t5_setwins", 1'b0, 10'h3E0, 2'd2, 1'b1, 4'b0100);
    pulse_eoi();
    tick();
    chk_all("t5_rereq", 1'b1, 10'h3E0, 2'd2, 1'b0, 4'b0100);
    pulse_ack();
    chk_all("t5_ack", 1'b0, 10'h3E0, 2'd2, 1'b1, 4'b0000);

    // Spurious handshakes
    pulse_ack();
    chk_all("t6_ack_svc", 1'b0, 10'h3E0, 2'd2, 1'b1, 4'b0000);
    pulse_eoi();
    pulse_eoi();
    chk_all("t6_eoi_idle", 1'b0, 10'h3E0, 2'd2, 1'b0, 4'b0000);
    pulse_ack();
    chk_all("t6_ack_idle", 1'b0, 10'h3E0, 2'd2, 1'b0, 4'b0000);
    bus_if.irq = 4'b1000;
    tick();
    bus_if.irq = 4'b0000;
    tick();
    chk_all("t6_req3", 1'b1, 10'h3F0, 2'd3, 1'b0, 4'b1000);
    bus_if.int_ack = 1'b1;
    bus_if.int_eoi = 1'b1;
    tick();
    bus_if.int_ack = 1'b0;
    bus_if.int_eoi = 1'b0;
    chk_all("t6_ackeoi", 1'b0, 10'h3F0, 2'd3, 1'b1, 4'b0000);

    // Reset during SERVICE with a pending event
    bus_if.irq = 4'b0001;
    tick();
    bus_if.irq = 4'b0000;
    chk_all("t7_pre", 1'b0, 10'h3F0, 2'd3, 1'b1, 4'b0001);
    reset = 1'b1;
    tick();
    chk_all("t7_reset", 1'b0, 10'h3C0, 2'd0, 1'b0, 4'b0000);
    reset = 1'b0;
    bus_if.irq = 4'b0010;
    tick();
    bus_if.irq = 4'b0000;
    tick();
    chk_all("t7_cfgclr", 1'b0, 10'h3C0, 2'd0, 1'b0, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
